// File: rtl/pic_seq_pkg.sv
// Shared types and encodings for the four-phase PIC-style instruction sequencer.
package pic_seq_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        WB     = 2'd3
    } seq_state_t;

    localparam logic [1:0] CLS_BYTE = 2'b00;
    localparam logic [1:0] CLS_BIT  = 2'b01;
    localparam logic [1:0] CLS_GOTO = 2'b10;
    localparam logic [1:0] CLS_LIT  = 2'b11;

    localparam logic [3:0] OP_NOP_MOVWF = 4'b0000;
    localparam logic [3:0] OP_DECFSZ    = 4'b1011;
    localparam logic [3:0] OP_INCFSZ    = 4'b1111;

    function automatic logic is_skip_op(input logic [3:0] op);
        return (op == OP_DECFSZ) || (op == OP_INCFSZ);
    endfunction

endpackage

// File: rtl/pic_seq_wen.sv
// Writeback decode: next-cycle write enables plus skip/goto flags, all squashed when annulled.
module pic_seq_wen
    import pic_seq_pkg::*;
(
    input  logic [7:2] inst_reg,   // operand bits [1:0] carry no class/op information
    input  logic       d,
    input  logic       annul,
    output logic       w_we_n,
    output logic       f_we_n,
    output logic       is_skip,
    output logic       is_goto
);

    logic [1:0] cls;
    logic [3:0] op;

    assign cls = inst_reg[7:6];
    assign op  = inst_reg[5:2];

    always_comb begin
        w_we_n  = 1'b0;
        f_we_n  = 1'b0;
        is_skip = 1'b0;
        is_goto = 1'b0;
        if (!annul) begin
            case (cls)
                CLS_BYTE: begin
                    if (!(op == OP_NOP_MOVWF && !d)) begin
                        f_we_n = d;
                        w_we_n = !d;
                    end
                    is_skip = is_skip_op(op);
                end
                CLS_BIT:  f_we_n  = 1'b1;
                CLS_LIT:  w_we_n  = 1'b1;
                CLS_GOTO: is_goto = 1'b1;
                default:  ;
            endcase
        end
    end

endmodule

// File: rtl/pic_sequencer.sv
// Four-phase fetch/decode/exec/writeback sequencer owning the PC and skip logic.
// Optional PIC_SEQ_SINGLE_STEP_EN adds a step input that releases one instruction per pulse.
module pic_sequencer
    import pic_seq_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            prog_req,
    output logic [PC_W-1:0] prog_addr,
    input  logic            prog_valid,
    input  logic [7:0]      prog_data,
    output logic [7:0]      inst_reg,
    input  logic            d,
    input  logic            alu_zero,
    output logic            alu_en,
    output logic            w_we,
    output logic            f_we,
    input  logic            halt,
`ifdef PIC_SEQ_SINGLE_STEP_EN
    input  logic            step,
`endif
    output logic            halted,
    output logic [1:0]      state_o
);

    seq_state_t      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [7:0]      inst_q, inst_d;
    logic            skip_q, skip_d;
    logic            zero_q, zero_d;
    logic            prog_req_q, prog_req_d;
    logic            alu_en_q, alu_en_d;
    logic            w_we_q, w_we_d;
    logic            f_we_q, f_we_d;
    logic            w_we_n, f_we_n, is_skip, is_goto;
    logic            idle_gate;

    // skip_q stays constant across EXEC and WB, so one decode serves both phases
    pic_seq_wen u_wen (
        .inst_reg (inst_q[7:2]),
        .d        (d),
        .annul    (skip_q),
        .w_we_n   (w_we_n),
        .f_we_n   (f_we_n),
        .is_skip  (is_skip),
        .is_goto  (is_goto)
    );

`ifdef PIC_SEQ_SINGLE_STEP_EN
    logic step_wait_q, step_wait_d;
    // halt outranks step: a step seen under halt is dropped
    assign step_wait_d = (state_q == WB) ? 1'b1
                       : (state_q == FETCH) ? (step_wait_q && !(step && !halt))
                       : step_wait_q;
    assign idle_gate   = halt || step_wait_q;
`else
    assign idle_gate   = halt;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        skip_d     = skip_q;
        zero_d     = zero_q;
        prog_req_d = 1'b0;
        alu_en_d   = 1'b0;
        w_we_d     = 1'b0;
        f_we_d     = 1'b0;
        case (state_q)
            FETCH: begin
                if (prog_req_q && prog_valid) begin
                    inst_d  = prog_data;
                    state_d = DECODE;
                end else begin
`ifdef PIC_SEQ_SINGLE_STEP_EN
                    prog_req_d = !halt && !step_wait_d;
`else
                    prog_req_d = !halt;
`endif
                end
            end
            DECODE: begin
                state_d  = EXEC;
                alu_en_d = 1'b1;
            end
            EXEC: begin
                zero_d  = alu_zero;
                w_we_d  = w_we_n;
                f_we_d  = f_we_n;
                state_d = WB;
            end
            WB: begin
                pc_d    = is_goto ? PC_W'(inst_q[5:0]) : pc_q + PC_W'(1);
                skip_d  = is_skip && zero_q;
                state_d = FETCH;
`ifdef PIC_SEQ_SINGLE_STEP_EN
                prog_req_d = 1'b0;
`else
                prog_req_d = !halt;
`endif
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            inst_q     <= 8'h00;
            skip_q     <= 1'b0;
            zero_q     <= 1'b0;
            prog_req_q <= 1'b0;
            alu_en_q   <= 1'b0;
            w_we_q     <= 1'b0;
            f_we_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            skip_q     <= skip_d;
            zero_q     <= zero_d;
            prog_req_q <= prog_req_d;
            alu_en_q   <= alu_en_d;
            w_we_q     <= w_we_d;
            f_we_q     <= f_we_d;
        end
    end

`ifdef PIC_SEQ_SINGLE_STEP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) step_wait_q <= 1'b0;
        else        step_wait_q <= step_wait_d;
    end
`endif

    assign prog_req  = prog_req_q;
    assign prog_addr = pc_q;
    assign inst_reg  = inst_q;
    assign alu_en    = alu_en_q;
    assign w_we      = w_we_q;
    assign f_we      = f_we_q;
    assign halted    = idle_gate && (state_q == FETCH);
    assign state_o   = state_q;

endmodule
